rp_spi_master: RTL and testbench

- Parametrised SPI master for the RedPitaya system bus.
- Successor to the single-mode SPI sim block. Adds:
  - programmable word length (1..DW bits)
  - all four CPOL/CPHA modes
  - programmable SCLK divider
  - NCS chip selects
  - receive register and status/done interrupt
- Sits on the sys_* register bus; drives an external SPI slave or the trigger front-end.

---
 rtl/rp_spi_master.sv | 233 +++++++++++++++++++++++
 tb/tb_rp_spi_master.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rp_spi_master.sv
// rtl/rp_spi_master.sv - SPI master on the sys_* register bus, CPOL/CPHA modes, variable length, divider, chip selects
// Optional internal loopback selected by CTRL[16] is compiled in when SPI_LOOPBACK_EN is defined.
module rp_spi_master #(
    parameter int DW   = 32,
    parameter int NCS  = 4,
    parameter int DIVW = 16
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic [31:0]    sys_addr,
    input  logic [31:0]    sys_wdata,
    input  logic           sys_wen,
    input  logic           sys_ren,
    output logic [31:0]    sys_rdata,
    output logic           sys_ack,
    output logic [NCS-1:0] cs_n,
    output logic           sclk,
    output logic           mosi,
    input  logic           miso,
    output logic           busy,
    output logic           done_irq
);
    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

    localparam logic [5:0] DW6 = 6'(DW);

    state_t            state_q, state_d;
    logic              cpol_q, cpol_d, cpha_q, cpha_d, lb_q, lb_d;
    logic [4:0]        lenm1_q, lenm1_d;
    logic [2:0]        csidx_q, csidx_d;
    logic [DIVW-1:0]   div_q, div_d;
    logic [DW-1:0]     rx_q, rx_d;
    logic              done_q, done_d, ovr_q, ovr_d;
    logic              run_cpol_q, run_cpol_d, run_cpha_q, run_cpha_d, run_lb_q, run_lb_d;
    logic [5:0]        run_len_q, run_len_d;
    logic [DIVW-1:0]   run_div_q, run_div_d;
    logic [DIVW-1:0]   cnt_q, cnt_d;
    logic [6:0]        edge_q, edge_d;
    logic [DW-1:0]     tx_q, tx_d, rxsh_q, rxsh_d;
    logic              sclk_q, sclk_d, mosi_q, mosi_d;
    logic [NCS-1:0]    cs_n_q, cs_n_d;
    logic              ack_q, ack_d, irq_q, irq_d;
    logic [31:0]       rdata_q, rdata_d;

    logic [5:0]        len_full, len_sat;
    logic [DW-1:0]     tx_al;
    logic              leading, last_edge, sbit;

    assign busy      = (state_q != IDLE);
    assign sclk      = (state_q == IDLE) ? cpol_q : sclk_q;
    assign mosi      = mosi_q;
    assign cs_n      = cs_n_q;
    assign sys_ack   = ack_q;
    assign sys_rdata = rdata_q;
    assign done_irq  = irq_q;

    assign len_full  = {1'b0, lenm1_q} + 6'd1;
    assign len_sat   = (len_full > DW6) ? DW6 : len_full;
    // Left-align the word so the current output bit is always the top bit.
    assign tx_al     = sys_wdata[DW-1:0] << (DW6 - len_sat);
    assign leading   = ~edge_q[0];
    assign last_edge = (edge_q == ({run_len_q, 1'b0} - 7'd1));
    assign sbit      = run_lb_q ? mosi_q : miso;

    always_comb begin
        state_d    = state_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        lb_d       = lb_q;
        lenm1_d    = lenm1_q;
        csidx_d    = csidx_q;
        div_d      = div_q;
        rx_d       = rx_q;
        done_d     = done_q;
        ovr_d      = ovr_q;
        run_cpol_d = run_cpol_q;
        run_cpha_d = run_cpha_q;
        run_lb_d   = run_lb_q;
        run_len_d  = run_len_q;
        run_div_d  = run_div_q;
        cnt_d      = cnt_q;
        edge_d     = edge_q;
        tx_d       = tx_q;
        rxsh_d     = rxsh_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        cs_n_d     = cs_n_q;
        irq_d      = 1'b0;
        ack_d      = sys_wen | sys_ren;
        rdata_d    = 32'd0;

        // Read data is built from current state, so a same-cycle write is not visible.
        if (sys_ren) begin
            case (sys_addr[4:0])
                5'h00:   rdata_d = {15'd0, lb_q, 5'd0, csidx_q, 1'b0, lenm1_q, cpha_q, cpol_q};
                5'h08:   rdata_d = 32'(rx_q);
                5'h0C:   rdata_d = 32'(div_q);
                5'h10:   rdata_d = {29'd0, ovr_q, done_q, busy};
                default: rdata_d = 32'd0;
            endcase
            if (sys_addr[4:0] == 5'h08) done_d = 1'b0;
            if (sys_addr[4:0] == 5'h10) ovr_d  = 1'b0;
        end

        if (sys_wen) begin
            case (sys_addr[4:0])
                5'h00: begin
                    cpol_d  = sys_wdata[0];
                    cpha_d  = sys_wdata[1];
                    lenm1_d = sys_wdata[6:2];
                    csidx_d = sys_wdata[10:8];
`ifdef SPI_LOOPBACK_EN
                    lb_d    = sys_wdata[16];
`else
                    lb_d    = 1'b0;
`endif
                end
                5'h0C:   div_d = sys_wdata[DIVW-1:0];
                default: ;
            endcase
        end

        case (state_q)
            IDLE: begin
                if (sys_wen && sys_addr[4:0] == 5'h04) begin
                    state_d    = SETUP;
                    run_cpol_d = cpol_q;
                    run_cpha_d = cpha_q;
                    run_lb_d   = lb_q;
                    run_len_d  = len_sat;
                    run_div_d  = div_q;
                    cnt_d      = '0;
                    edge_d     = '0;
                    rxsh_d     = '0;
                    sclk_d     = cpol_q;
                    mosi_d     = cpha_q ? 1'b0 : tx_al[DW-1];
                    tx_d       = cpha_q ? tx_al : (tx_al << 1);
                    cs_n_d     = '1;
                    for (int i = 0; i < NCS; i++)
                        if (csidx_q == 3'(i)) cs_n_d[i] = 1'b0;
                end
            end
            SETUP, SHIFT: begin
                if (cnt_q == run_div_q) begin
                    cnt_d  = '0;
                    sclk_d = ~sclk_q;
                    edge_d = edge_q + 7'd1;
                    if (leading ^ run_cpha_q)
                        rxsh_d = {rxsh_q[DW-2:0], sbit};
                    // cpha=0 shifts on trailing edges but must not disturb the last bit.
                    if (run_cpha_q ? leading : (!leading && !last_edge)) begin
                        mosi_d = tx_q[DW-1];
                        tx_d   = tx_q << 1;
                    end
                    state_d = last_edge ? HOLD : SHIFT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (cnt_q == run_div_q) begin
                    state_d = IDLE;
                    cs_n_d  = '1;
                    mosi_d  = 1'b0;
                    rx_d    = rxsh_q;
                    done_d  = 1'b1;
                    irq_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (busy && sys_wen && sys_addr[4:0] == 5'h04) ovr_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            lb_q       <= 1'b0;
            lenm1_q    <= '0;
            csidx_q    <= '0;
            div_q      <= '0;
            rx_q       <= '0;
            done_q     <= 1'b0;
            ovr_q      <= 1'b0;
            run_cpol_q <= 1'b0;
            run_cpha_q <= 1'b0;
            run_lb_q   <= 1'b0;
            run_len_q  <= '0;
            run_div_q  <= '0;
            cnt_q      <= '0;
            edge_q     <= '0;
            tx_q       <= '0;
            rxsh_q     <= '0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            cs_n_q     <= '1;
            ack_q      <= 1'b0;
            irq_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            lb_q       <= lb_d;
            lenm1_q    <= lenm1_d;
            csidx_q    <= csidx_d;
            div_q      <= div_d;
            rx_q       <= rx_d;
            done_q     <= done_d;
            ovr_q      <= ovr_d;
            run_cpol_q <= run_cpol_d;
            run_cpha_q <= run_cpha_d;
            run_lb_q   <= run_lb_d;
            run_len_q  <= run_len_d;
            run_div_q  <= run_div_d;
            cnt_q      <= cnt_d;
            edge_q     <= edge_d;
            tx_q       <= tx_d;
            rxsh_q     <= rxsh_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            cs_n_q     <= cs_n_d;
            ack_q      <= ack_d;
            irq_q      <= irq_d;
            rdata_q    <= rdata_d;
        end
    end
endmodule

// File: tb/tb_rp_spi_master.sv
// tb/tb_rp_spi_master.sv - directed self-checking bench for rp_spi_master with a behavioural SPI slave
module tb_rp_spi_master;
    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic [31:0] sys_addr = '0, sys_wdata = '0;
    logic        sys_wen = 1'b0, sys_ren = 1'b0;
    logic [31:0] sys_rdata;
    logic        sys_ack;
    logic [3:0]  cs_n;
    logic        sclk, mosi, busy, done_irq;
    logic        miso_r = 1'b0;

    int checks = 0;
    int failures = 0;

    rp_spi_master #(.DW(32), .NCS(4), .DIVW(16)) dut (
        .clk(clk), .rstn(rstn), .sys_addr(sys_addr), .sys_wdata(sys_wdata),
        .sys_wen(sys_wen), .sys_ren(sys_ren), .sys_rdata(sys_rdata), .sys_ack(sys_ack),
        .cs_n(cs_n), .sclk(sclk), .mosi(mosi), .miso(miso_r), .busy(busy), .done_irq(done_irq)
    );

    always #5 clk = ~clk;

    // Slave: selected while busy, shifts MSB first in the mode given by slv_cpha.
    logic [31:0] slv_tx = '0, slv_rx = '0;
    int          slv_len = 8, slv_bit = 0, slv_edges = 0;
    logic        slv_cpha = 1'b0;

    always @(posedge busy) begin
        slv_rx = '0;
        slv_edges = 0;
        slv_bit = slv_len - 1;
        if (!slv_cpha) miso_r = slv_tx[slv_bit];
    end

    always @(sclk) begin
        if (busy && rstn) begin
            slv_edges++;
            if (slv_edges % 2 == 1) begin
                if (!slv_cpha) slv_rx = {slv_rx[30:0], mosi};
                else if (slv_bit >= 0) miso_r = slv_tx[slv_bit];
            end else begin
                if (!slv_cpha) begin
                    if (slv_bit > 0) begin
                        slv_bit--;
                        miso_r = slv_tx[slv_bit];
                    end
                end else begin
                    slv_rx = {slv_rx[30:0], mosi};
                    slv_bit--;
                end
            end
        end
    end

    int   mon_cs = 0, mon_edges = 0, mon_irq = 0;
    logic mon_prev = 1'b0;

    always @(posedge clk) begin
        #1;
        if (cs_n != 4'hF) mon_cs++;
        if (sclk != mon_prev) mon_edges++;
        mon_prev = sclk;
        if (done_irq) mon_irq++;
    end

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        sys_addr = a; sys_wdata = d; sys_wen = 1'b1;
        @(negedge clk);
        sys_wen = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        sys_addr = a; sys_ren = 1'b1;
        @(negedge clk);
        sys_ren = 1'b0;
        d = sys_rdata;
    endtask

    task automatic clear_mon();
        mon_cs = 0; mon_edges = 0; mon_irq = 0; mon_prev = sclk;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy) begin
            failures++;
            $display("FAIL %s_timeout busy=%b required 0", name, busy);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic xfer(input logic [31:0] ctrl, input logic [31:0] div, input logic [31:0] tx,
                        input logic [31:0] stx, input int len, input string name);
        bus_write(32'h00, ctrl);
        bus_write(32'h0C, div);
        slv_tx = stx; slv_len = len; slv_cpha = ctrl[1];
        clear_mon();
        bus_write(32'h04, tx);
        wait_idle(name);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        #1 rstn = 1'b0;
        #1;
        checks++; if (cs_n !== 4'hF) begin failures++; $display("FAIL rst_cs_n got %h want f", cs_n); end
        checks++; if (sclk !== 1'b0) begin failures++; $display("FAIL rst_sclk got %b want 0", sclk); end
        checks++; if (mosi !== 1'b0) begin failures++; $display("FAIL rst_mosi got %b want 0", mosi); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got %b want 0", busy); end
        checks++; if (done_irq !== 1'b0) begin failures++; $display("FAIL rst_irq got %b want 0", done_irq); end
        checks++; if (sys_ack !== 1'b0 || sys_rdata !== 32'd0) begin failures++; $display("FAIL rst_bus got ack=%b rdata=%h want 0/0", sys_ack, sys_rdata); end
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        bus_read(32'h00, d);
        checks++; if (d !== 32'd0 || sys_ack !== 1'b1) begin failures++; $display("FAIL rst_ctrl got %h ack=%b want 0 ack=1", d, sys_ack); end
        @(negedge clk);
        checks++; if (sys_ack !== 1'b0) begin failures++; $display("FAIL ack_pulse got %b want 0", sys_ack); end
        bus_read(32'h0C, d);
        checks++; if (d !== 32'd0) begin failures++; $display("FAIL rst_div got %h want 0", d); end
        bus_read(32'h10, d);
        checks++; if (d !== 32'd0) begin failures++; $display("FAIL rst_status got %h want 0", d); end
        bus_read(32'h14, d);
        checks++; if (d !== 32'd0) begin failures++; $display("FAIL unmapped got %h want 0", d); end
        @(negedge clk);
        sys_addr = 32'h00; sys_wdata = 32'h1C; sys_wen = 1'b1; sys_ren = 1'b1;
        @(negedge clk);
        sys_wen = 1'b0; sys_ren = 1'b0;
        checks++; if (sys_rdata !== 32'd0) begin failures++; $display("FAIL rw_same got %h want 0", sys_rdata); end
        bus_read(32'h00, d);
        checks++; if (d !== 32'h1C) begin failures++; $display("FAIL rw_after got %h want 1c", d); end
    endtask

    task automatic test_mode0();
        logic [31:0] d;
        xfer(32'h1C, 32'd1, 32'hA5, 32'h3C, 8, "mode0");
        checks++; if (mon_cs != 34) begin failures++; $display("FAIL m0_cs_cycles got %0d want 34", mon_cs); end
        checks++; if (mon_edges != 16) begin failures++; $display("FAIL m0_edges got %0d want 16", mon_edges); end
        checks++; if (mon_irq != 1) begin failures++; $display("FAIL m0_irq got %0d want 1", mon_irq); end
        checks++; if (slv_rx !== 32'hA5) begin failures++; $display("FAIL m0_slave got %h want a5", slv_rx); end
        bus_read(32'h10, d);
        checks++; if (d !== 32'h2) begin failures++; $display("FAIL m0_status got %h want 2", d); end
        bus_read(32'h08, d);
        checks++; if (d !== 32'h3C) begin failures++; $display("FAIL m0_rx got %h want 3c", d); end
        bus_read(32'h10, d);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL m0_done_clr got %h want 0", d); end
    endtask

    task automatic test_modes();
        logic [31:0] d;
        for (int m = 1; m < 4; m++) begin
            bus_write(32'h00, 32'h3C | 32'(m));
            checks++; if (sclk !== 1'(m & 1)) begin failures++; $display("FAIL mode%0d_idle got %b want %0d", m, sclk, m & 1); end
            xfer(32'h3C | 32'(m), 32'd2, 32'h8001, 32'h1234, 16, "modes");
            checks++; if (mon_cs != 99 || mon_edges != 32) begin failures++; $display("FAIL mode%0d_timing got cs=%0d edges=%0d want 99/32", m, mon_cs, mon_edges); end
            checks++; if (slv_rx !== 32'h8001) begin failures++; $display("FAIL mode%0d_slave got %h want 8001", m, slv_rx); end
            bus_read(32'h08, d);
            checks++; if (d !== 32'h1234) begin failures++; $display("FAIL mode%0d_rx got %h want 1234", m, d); end
        end
    endtask

    task automatic test_len32();
        logic [31:0] d;
        xfer(32'h7C, 32'd0, 32'hDEADBEEF, 32'hCAFEF00D, 32, "len32");
        checks++; if (mon_cs != 65) begin failures++; $display("FAIL l32_cs got %0d want 65", mon_cs); end
        checks++; if (mon_edges != 64) begin failures++; $display("FAIL l32_edges got %0d want 64", mon_edges); end
        checks++; if (slv_rx !== 32'hDEADBEEF) begin failures++; $display("FAIL l32_slave got %h want deadbeef", slv_rx); end
        bus_read(32'h08, d);
        checks++; if (d !== 32'hCAFEF00D) begin failures++; $display("FAIL l32_rx got %h want cafef00d", d); end
    endtask

    task automatic test_overrun();
        logic [31:0] d;
        bus_write(32'h00, 32'h1C);
        bus_write(32'h0C, 32'd3);
        slv_tx = 32'h5B; slv_len = 8; slv_cpha = 1'b0;
        bus_write(32'h04, 32'h96);
        bus_write(32'h04, 32'h00);
        bus_read(32'h10, d);
        checks++; if (d !== 32'h5) begin failures++; $display("FAIL ovr_status got %h want 5", d); end
        wait_idle("ovr");
        checks++; if (slv_rx !== 32'h96) begin failures++; $display("FAIL ovr_slave got %h want 96", slv_rx); end
        bus_read(32'h10, d);
        checks++; if (d !== 32'h2) begin failures++; $display("FAIL ovr_status_end got %h want 2", d); end
        bus_read(32'h08, d);
        checks++; if (d !== 32'h5B) begin failures++; $display("FAIL ovr_rx got %h want 5b", d); end
    endtask

    task automatic test_bad_cs();
        logic [31:0] d;
        xfer(32'h51C, 32'd0, 32'h33, 32'h00, 8, "badcs");
        checks++; if (mon_cs != 0) begin failures++; $display("FAIL badcs_cs got %0d want 0", mon_cs); end
        checks++; if (mon_edges != 16) begin failures++; $display("FAIL badcs_edges got %0d want 16", mon_edges); end
        checks++; if (mon_irq != 1) begin failures++; $display("FAIL badcs_irq got %0d want 1", mon_irq); end
        bus_read(32'h08, d);
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        bus_write(32'h00, 32'h1C);
        bus_write(32'h0C, 32'd1);
        slv_tx = 32'h11; slv_len = 8; slv_cpha = 1'b0;
        clear_mon();
        bus_write(32'h04, 32'hFF);
        repeat (10) @(negedge clk);
        rstn = 1'b0;
        #1;
        checks++; if (cs_n !== 4'hF || sclk !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL midrst_out got cs=%h sclk=%b busy=%b want f/0/0", cs_n, sclk, busy); end
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (mon_irq != 0) begin failures++; $display("FAIL midrst_irq got %0d want 0", mon_irq); end
        xfer(32'h1C, 32'd1, 32'h3A, 32'hC5, 8, "midrst");
        checks++; if (slv_rx !== 32'h3A || mon_irq != 1) begin failures++; $display("FAIL midrst_slave got %h irq=%0d want 3a/1", slv_rx, mon_irq); end
        bus_read(32'h08, d);
        checks++; if (d !== 32'hC5) begin failures++; $display("FAIL midrst_rx got %h want c5", d); end
    endtask

    task automatic test_loopback();
        logic [31:0] d;
`ifdef SPI_LOOPBACK_EN
        xfer(32'h1001C, 32'd1, 32'h5A, 32'hFF, 8, "loop");
        bus_read(32'h08, d);
        checks++; if (d !== 32'h5A) begin failures++; $display("FAIL loop_rx got %h want 5a", d); end
        bus_read(32'h00, d);
        checks++; if (d !== 32'h1001C) begin failures++; $display("FAIL loop_ctrl got %h want 1001c", d); end
`else
        bus_write(32'h00, 32'h1001C);
        bus_read(32'h00, d);
        checks++; if (d !== 32'h1C) begin failures++; $display("FAIL loop_ctrl got %h want 1c", d); end
`endif
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_modes();
        test_len32();
        test_overrun();
        test_bad_cs();
        test_reset_mid();
        test_loopback();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
